game_round_controller: RTL and testbench
========================================

Name: game_round_controller

Overview:
- Session-level sequencer above the game master FSM. It issues the launch that starts each round and classifies each finished round as a hit or a miss from the master FSM's game_won / end-of-game-timer signals.
- It keeps score, lives and difficulty level, inserts a fixed pause between rounds and auto-launches the next round.
- It stops at game over until the player presses launch again.
- Its outputs feed the master FSM launch input, the score display (target_count) and sprite speed selection (level).

Parameters:
- LIVES_INIT, 3, lives loaded at session start (1..7)
- HITS_PER_LEVEL, 4, consecutive-or-not hits needed to advance one level (>=1)
- MAX_LEVEL, 7, saturation value of level (<=7)
- PAUSE_CYCLES, 24'd12_500_000, inter-round pause length in clk cycles (>=1)
- PAUSE_WIDTH, 24, width of the pause counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- launch_key  in  1  player launch key, level, already synchronous to clk
- game_won  in  1  master FSM game_won, level
- end_of_game_timer_running  in  1  master FSM end-of-round timer busy, level
- launch_out  out  1  one-cycle launch pulse to master FSM
- target_count  out  16  score (hits this session)
- lives  out  3  remaining lives
- level  out  3  difficulty level, 0-based
- game_over  out  1  high while in GAME_OVER
- busy  out  1  high in PLAYING, EVAL, PAUSE

Behaviour:
- All outputs are registered.
- Reset values (async assert): state=IDLE, launch_out=0, target_count=0, lives=LIVES_INIT, level=0, game_over=0, busy=0. Internal registers reset as follows: hit counter=0, pause counter=0, won_q=0, key_q=1, run_q=0. key_q=1 means a key held through reset does not launch.
- Edge detection: key_rise = launch_key & ~key_q. run_rise = running & ~run_q. run_fall = ~running & run_q. key_q and run_q update every cycle.
- won_q loads game_won on run_rise, in any state. The round outcome is frozen when the end timer starts.
- IDLE: key_rise -> PLAYING, launch_out=1 for the following cycle only.
- PLAYING: run_fall -> EVAL. key_rise is ignored.
- EVAL (exactly one cycle), hit path (won_q=1):
  - target_count+1, saturating at 16'hFFFF.
  - If the hit counter == HITS_PER_LEVEL-1, the hit counter goes to 0 and level goes to level+1 (saturating at MAX_LEVEL). Otherwise the hit counter increments.
  - Next state PAUSE.
- EVAL, miss path (won_q=0):
  - lives-1.
  - If lives was 1, lives becomes 0 and the next state is GAME_OVER. Otherwise the next state is PAUSE.
  - The hit counter is unchanged.
- PAUSE: the pause counter loads PAUSE_CYCLES-1 on entry and decrements each cycle. On the cycle it reads 0: launch_out=1 for one cycle, next state PLAYING. The launch pulse therefore fires PAUSE_CYCLES cycles after EVAL.
- GAME_OVER: game_over=1; score, level and lives=0 are held for display. On key_rise: target_count=0, lives=LIVES_INIT, level=0, hit counter=0, launch_out=1 for one cycle, next state PLAYING.
- Edges on end_of_game_timer_running are ignored outside PLAYING, except the won_q capture. key_rise is ignored in PLAYING, EVAL and PAUSE.
- launch_out is never high in two consecutive cycles.
- rst asserted mid-round or mid-pause returns everything to reset values immediately. No launch is issued on release.

Test Plan:
- Reset then launch: rst pulse; launch_key 0->1 -> launch_out=1 for exactly 1 cycle; busy=1, lives=3, target_count=0. Holding launch_key high afterwards gives no further launch.
- Hit and pause (PAUSE_CYCLES=4): game_won=1, running 0->1->0 -> EVAL then target_count=1, lives=3. launch_out pulses exactly 4 cycles after the EVAL cycle.
- Level up: 4 hits -> level=1, target_count=4. 28 more hits -> level saturates at 7. Set target_count near 16'hFFFF by forcing -> stays 16'hFFFF.
- Game over: 3 misses (game_won=0) -> lives 3->2->1->0; game_over=1, busy=0, no launch_out after the third miss. launch_key rise -> lives=3, score=0, level=0, one launch_out.
- Outcome latch: game_won=1 at run_rise, dropped to 0 before run_fall -> counted as hit. Timer pulse while in IDLE or PAUSE -> no score or lives change.
- Async reset mid-pause: rst asserted with the pause counter at 2 -> outputs go to reset values without waiting for a clock edge. No launch_out after release.

Source files
------------

// File: rtl/game_round_controller.sv
// Session sequencer above the game master FSM: launches rounds,
// scores hits/misses, tracks lives and level, pauses between rounds.
module game_round_controller #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned MAX_LEVEL      = 7,
  parameter int unsigned PAUSE_WIDTH    = 24,
  parameter logic [PAUSE_WIDTH-1:0] PAUSE_CYCLES = 24'd12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        launch_key,
  input  logic        game_won,
  input  logic        end_of_game_timer_running,
  output logic        launch_out,
  output logic [15:0] target_count,
  output logic [2:0]  lives,
  output logic [2:0]  level,
  output logic        game_over,
  output logic        busy
);

  localparam int unsigned HW = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [HW-1:0] HIT_LAST = HW'(HITS_PER_LEVEL - 1);
  localparam logic [2:0] LVL_MAX   = 3'(MAX_LEVEL);
  localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
  localparam logic [PAUSE_WIDTH-1:0] CNT_LOAD =
    PAUSE_CYCLES - PAUSE_WIDTH'(1);

  logic [2:0]             state_q, state_d;
  logic                   launch_q, launch_d;
  logic [15:0]            score_q, score_d;
  logic [2:0]             lives_q, lives_d;
  logic [2:0]             level_q, level_d;
  logic [HW-1:0]          hits_q, hits_d;
  logic [PAUSE_WIDTH-1:0] cnt_q, cnt_d;
  logic                   over_q, over_d;
  logic                   busy_q, busy_d;
  logic                   won_q, key_q, run_q;

  logic running;
  logic key_rise, run_rise, run_fall;

  assign running  = end_of_game_timer_running;
  assign key_rise = launch_key & ~key_q;
  assign run_rise = running & ~run_q;
  assign run_fall = ~running & run_q;

  always_comb begin
    state_d  = state_q;
    launch_d = 1'b0;
    score_d  = score_q;
    lives_d  = lives_q;
    level_d  = level_q;
    hits_d   = hits_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (key_rise) begin
          state_d  = S_PLAY;
          launch_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (run_fall) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (won_q) begin
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          if (hits_q == HIT_LAST) begin
            hits_d = '0;
            if (level_q < LVL_MAX) level_d = level_q + 3'd1;
          end else begin
            hits_d = hits_q + HW'(1);
          end
          state_d = S_PAUSE;
          cnt_d   = CNT_LOAD;
        end else if (lives_q == 3'd1) begin
          lives_d = 3'd0;
          state_d = S_OVER;
        end else begin
          lives_d = lives_q - 3'd1;
          state_d = S_PAUSE;
          cnt_d   = CNT_LOAD;
        end
      end
      S_PAUSE: begin
        if (cnt_q == '0) state_d = S_PLAY;
        else             cnt_d   = cnt_q - PAUSE_WIDTH'(1);
      end
      S_OVER: begin
        if (key_rise) begin
          score_d  = 16'd0;
          lives_d  = LIVES_RST;
          level_d  = 3'd0;
          hits_d   = '0;
          launch_d = 1'b1;
          state_d  = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Register the pulse so it is high on the pause cycle that reads zero
    if (state_d == S_PAUSE && cnt_d == '0) launch_d = 1'b1;
    busy_d = (state_d == S_PLAY) || (state_d == S_EVAL) ||
             (state_d == S_PAUSE);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      launch_q <= 1'b0;
      score_q  <= 16'd0;
      lives_q  <= LIVES_RST;
      level_q  <= 3'd0;
      hits_q   <= '0;
      cnt_q    <= '0;
      over_q   <= 1'b0;
      busy_q   <= 1'b0;
      won_q    <= 1'b0;
      key_q    <= 1'b1;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      level_q  <= level_d;
      hits_q   <= hits_d;
      cnt_q    <= cnt_d;
      over_q   <= over_d;
      busy_q   <= busy_d;
      key_q    <= launch_key;
      run_q    <= running;
      if (run_rise) won_q <= game_won;
    end
  end

  assign launch_out   = launch_q;
  assign target_count = score_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign game_over    = over_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: table session, model-checked
// random rounds, saturation, game over and async reset corners.
module tb_game_round_controller;

  localparam int P   = 4;
  localparam int LI  = 3;
  localparam int HPL = 4;
  localparam int ML  = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        launch_key;
  logic        game_won;
  logic        running;
  logic        launch_out;
  logic [15:0] target_count;
  logic [2:0]  lives;
  logic [2:0]  level;
  logic        game_over;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int m_hits;
  int m_lives;

  typedef struct {
    bit won;
    bit early;
    bit noise;
    int score;
    int lives;
    int level;
    bit over;
  } vec_t;

  vec_t tbl[7];

  game_round_controller #(
    .LIVES_INIT(LI),
    .HITS_PER_LEVEL(HPL),
    .MAX_LEVEL(ML),
    .PAUSE_WIDTH(24),
    .PAUSE_CYCLES(24'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .launch_key(launch_key),
    .game_won(game_won),
    .end_of_game_timer_running(running),
    .launch_out(launch_out),
    .target_count(target_count),
    .lives(lives),
    .level(level),
    .game_over(game_over),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input int sc,
                          input int lv, input int lvl,
                          input bit ov, input bit bz);
    chk({nm, ".score"}, target_count, sc);
    chk({nm, ".lives"}, lives, lv);
    chk({nm, ".level"}, level, lvl);
    chk({nm, ".over"}, game_over, ov);
    chk({nm, ".busy"}, busy, bz);
  endtask

  // One round from PLAYING: timer rise, optional drops and noise,
  // timer fall, then the EVAL result and the pause launch timing.
  task automatic do_round(input bit won, input bit early,
                          input bit noise, input int e_sc,
                          input int e_lv, input int e_lvl,
                          input bit e_ov);
    logic [15:0] seen;
    logic [15:0] want;
    seen = '0;
    want = '0;
    @(negedge clk);
    running  = 1'b1;
    game_won = won;
    @(negedge clk);
    if (early) game_won = 1'b0;
    launch_key = 1'($urandom_range(0, 1));
    @(negedge clk);
    launch_key = 1'($urandom_range(0, 1));
    @(negedge clk);
    running    = 1'b0;
    game_won   = 1'($urandom_range(0, 1));
    launch_key = 1'b0;
    for (int k = 1; k <= P + 3; k++) begin
      @(negedge clk);
      seen[k] = launch_out;
      if (k == 2) begin
        chk_outs("round", e_sc, e_lv, e_lvl, e_ov, !e_ov);
        if (noise) begin
          running  = 1'b1;
          game_won = 1'($urandom_range(0, 1));
        end
      end
      if (k == 3) running = 1'b0;
    end
    if (!e_ov) want[P+1] = 1'b1;
    chk("round.launch", seen, want);
  endtask

  task automatic model_round(input bit won);
    int sc;
    int lvl;
    if (won) m_hits++;
    else     m_lives--;
    sc  = (m_hits > 65535) ? 65535 : m_hits;
    lvl = (m_hits / HPL > ML) ? ML : m_hits / HPL;
    do_round(won, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), sc, m_lives, lvl,
             m_lives == 0);
  endtask

  task automatic press_key();
    logic [3:0] seen;
    seen = '0;
    @(negedge clk);
    launch_key = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      seen[k] = launch_out;
      if (k == 1) chk_outs("key", 0, LI, 0, 1'b0, 1'b1);
    end
    chk("key.launch", seen, 4'b0010);
    launch_key = 1'b0;
    m_hits  = 0;
    m_lives = LI;
  endtask

  initial begin
    int hi;
    tbl = '{
      '{1'b1, 1'b0, 1'b1, 1, 3, 0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2, 3, 0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 2, 2, 0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 3, 2, 0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 4, 2, 1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4, 1, 1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 4, 0, 1, 1'b1}
    };
    rst        = 1'b1;
    launch_key = 1'b1;
    game_won   = 1'b0;
    running    = 1'b0;
    m_hits     = 0;
    m_lives    = LI;
    repeat (2) @(negedge clk);
    chk("rst.launch", launch_out, 0);
    chk_outs("rst", 0, LI, 0, 1'b0, 1'b0);

    // Key held through reset must not launch
    rst = 1'b0;
    hi  = 0;
    repeat (3) begin
      @(negedge clk);
      if (launch_out) hi++;
    end
    chk("held_key.launches", hi, 0);

    // Timer pulse in IDLE changes nothing
    running  = 1'b1;
    game_won = 1'b1;
    @(negedge clk);
    running = 1'b0;
    repeat (2) @(negedge clk);
    chk_outs("idle_pulse", 0, LI, 0, 1'b0, 1'b0);
    launch_key = 1'b0;
    @(negedge clk);
    press_key();

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].won) m_hits++;
      else            m_lives--;
      do_round(tbl[i].won, tbl[i].early, tbl[i].noise,
               tbl[i].score, tbl[i].lives, tbl[i].level,
               tbl[i].over);
    end
    press_key();

    for (int i = 0; i < 32; i++) model_round(1'b1);
    chk("sat.level", level, ML);

    @(negedge clk);
    force dut.score_q = 16'hFFFE;
    @(negedge clk);
    release dut.score_q;
    m_hits = 65534;
    chk("sat.forced", target_count, 16'hFFFE);
    model_round(1'b1);
    model_round(1'b1);
    chk("sat.score", target_count, 16'hFFFF);

    for (int i = 0; i < 40; i++) begin
      model_round(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      if (m_lives == 0) press_key();
    end

    // Async reset with the pause counter at 2
    @(negedge clk);
    running  = 1'b1;
    game_won = 1'b1;
    @(negedge clk);
    @(negedge clk);
    running = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_pause.busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async.launch", launch_out, 0);
    chk_outs("async", 0, LI, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    hi  = 0;
    repeat (8) begin
      @(negedge clk);
      if (launch_out) hi++;
    end
    chk("post_rst.launches", hi, 0);
    chk_outs("post_rst", 0, LI, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
